// File: rtl/mem_arbiter_if.sv
// Bus bundle shared by the fetch path, the data path and the memory port of
// the memory arbiter. The slave modport is the arbiter's view. The master
// modport is the view of the requesters and the memory that surround it.
interface mem_arbiter_if #(
    parameter int AWIDTH = 15,
    parameter int DWIDTH = 32
);
    logic              if_req;
    logic [AWIDTH-1:0] if_addr;
    logic              if_gnt;
    logic              if_stall;
    logic              if_rvalid;
    logic [DWIDTH-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [AWIDTH-1:0] d_addr;
    logic [DWIDTH-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DWIDTH-1:0] d_rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_stall, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_stall, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter. The instruction fetch path and the load/store
// data path share one memory. At most one access is granted per cycle, and
// read data comes back registered one cycle after the grant. A wait counter
// bounds how long fetch can lose to continuous data traffic.
module mem_arbiter #(
    parameter int AWIDTH         = 15,
    parameter int DWIDTH         = 32,
    parameter int MAX_FETCH_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);

    localparam int WCW = (MAX_FETCH_WAIT > 0) ? $clog2(MAX_FETCH_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_FETCH_WAIT);

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_FETCH = 2'd1,
        RESP_LOAD  = 2'd2,
        RESP_STORE = 2'd3
    } resp_state_t;

    resp_state_t       resp_state_q, resp_state_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [DWIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DWIDTH-1:0] d_rdata_q, d_rdata_d;

    logic              ifGnt;
    logic              dGnt;
    logic              memRd;
    logic              memWr;
    logic [AWIDTH-1:0] memAddr;
    logic [DWIDTH-1:0] memWdata;

    // Pick the winner for this cycle and derive the memory drive, the next
    // response state, the next wait count and the read data captures.
    always_comb begin
        ifGnt        = 1'b0;
        dGnt         = 1'b0;
        memRd        = 1'b0;
        memWr        = 1'b0;
        memAddr      = '0;
        memWdata     = '0;
        resp_state_d = RESP_NONE;
        wait_cnt_d   = wait_cnt_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        if (!rst) begin
            if (bus.if_req && bus.d_req) begin
                if (wait_cnt_q == WAIT_LIMIT) begin
                    ifGnt = 1'b1;
                end else begin
                    dGnt = 1'b1;
                end
            end else if (bus.if_req) begin
                ifGnt = 1'b1;
            end else if (bus.d_req) begin
                dGnt = 1'b1;
            end
        end

        if (!bus.if_req || ifGnt) begin
            wait_cnt_d = '0;
        end else if (dGnt) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (ifGnt) begin
            memRd        = 1'b1;
            memAddr      = bus.if_addr;
            resp_state_d = RESP_FETCH;
            if_rdata_d   = bus.mem_rdata;
        end else if (dGnt && bus.d_we) begin
            memWr        = 1'b1;
            memAddr      = bus.d_addr;
            memWdata     = bus.d_wdata;
            resp_state_d = RESP_STORE;
        end else if (dGnt) begin
            memRd        = 1'b1;
            memAddr      = bus.d_addr;
            resp_state_d = RESP_LOAD;
            d_rdata_d    = bus.mem_rdata;
        end
    end

    // Register the response state, the wait count and the captured read data.
    // Reset drops any response that is still pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_state_q <= RESP_NONE;
            wait_cnt_q   <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            resp_state_q <= resp_state_d;
            wait_cnt_q   <= wait_cnt_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.if_gnt    = ifGnt;
    assign bus.if_stall  = bus.if_req & ~ifGnt;
    assign bus.if_rvalid = (resp_state_q == RESP_FETCH);
    assign bus.if_rdata  = if_rdata_q;

    assign bus.d_gnt     = dGnt;
    assign bus.d_rvalid  = (resp_state_q == RESP_LOAD);
    assign bus.d_rdata   = d_rdata_q;

    assign bus.mem_rd    = memRd;
    assign bus.mem_wr    = memWr;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for the memory arbiter. It covers reset, idle, fetch
// streaming, store followed by fetch, fetch starvation, response routing and
// reset while a response is pending. The bench keeps a small behavioural
// memory whose word i holds 32'hA000_0000 + i after reset.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arbiter_if #(.AWIDTH(15), .DWIDTH(32)) bus ();

    mem_arbiter #(
        .AWIDTH(15),
        .DWIDTH(32),
        .MAX_FETCH_WAIT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] memArray [0:63];

    // Free-running clock with a 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory. It is reloaded with its known pattern on reset,
    // and a write lands at the grant edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) memArray[i] <= 32'hA000_0000 + 32'(i);
        end else if (bus.mem_wr) begin
            memArray[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
    end

    // Memory read data is combinational from the address and read strobe.
    assign bus.mem_rdata = bus.mem_rd ? memArray[bus.mem_addr[5:0]] : 32'h0;

    // Drive one cycle of inputs just after the falling edge. Outputs are then
    // sampled 1 time unit later, well away from the rising edge.
    task automatic applyStimulus(input logic r, input logic ifReq, input logic [14:0] ifAddr,
                                 input logic dReq, input logic dWe, input logic [14:0] dAddr,
                                 input logic [31:0] dWdata);
        @(negedge clk);
        rst         = r;
        bus.if_req  = ifReq;
        bus.if_addr = ifAddr;
        bus.d_req   = dReq;
        bus.d_we    = dWe;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset holds off grants. Stall follows the fetch request.
        applyStimulus(1'b1, 1'b1, 15'd1, 1'b1, 1'b0, 15'd2, 32'h0);
        checkOutput("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        checkOutput("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
        checkOutput("rst_if_stall", 32'(bus.if_stall), 32'd1);
        checkOutput("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        checkOutput("rst_mem_wr", 32'(bus.mem_wr), 32'd0);

        applyStimulus(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 15'd0, 32'h0);
        checkOutput("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        checkOutput("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        checkOutput("rst_if_rdata", bus.if_rdata, 32'h0);
        checkOutput("rst_d_rdata", bus.d_rdata, 32'h0);
        checkOutput("rst_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
        checkOutput("rst_if_stall_low", 32'(bus.if_stall), 32'd0);

        // Idle for 10 cycles: no memory strobes, no responses.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 15'd0, 32'h0);
            checkOutput("idle_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
            checkOutput("idle_rvalid", {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
        end

        // Fetch stream at 0,1,2. Data comes back one cycle behind the grant.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 15'(k), 1'b0, 1'b0, 15'd0, 32'h0);
            checkOutput("fs_if_gnt", 32'(bus.if_gnt), 32'd1);
            checkOutput("fs_if_stall", 32'(bus.if_stall), 32'd0);
            checkOutput("fs_mem_addr", 32'(bus.mem_addr), 32'(k));
            checkOutput("fs_mem_rd", 32'(bus.mem_rd), 32'd1);
            if (k > 0) begin
                checkOutput("fs_if_rvalid", 32'(bus.if_rvalid), 32'd1);
                checkOutput("fs_if_rdata", bus.if_rdata, 32'hA000_0000 + 32'(k - 1));
            end
        end
        applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 15'd0, 32'h0);
        checkOutput("fs_last_rvalid", 32'(bus.if_rvalid), 32'd1);
        checkOutput("fs_last_rdata", bus.if_rdata, 32'hA000_0002);
        checkOutput("fs_idle_gnt", 32'(bus.if_gnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 15'd0, 32'h0);
        checkOutput("fs_drop_rvalid", 32'(bus.if_rvalid), 32'd0);
        checkOutput("fs_hold_rdata", bus.if_rdata, 32'hA000_0002);

        // Store 0xDEADBEEF to address 5, then fetch address 5.
        applyStimulus(1'b0, 1'b0, 15'd0, 1'b1, 1'b1, 15'd5, 32'hDEAD_BEEF);
        checkOutput("st_d_gnt", 32'(bus.d_gnt), 32'd1);
        checkOutput("st_mem_wr", 32'(bus.mem_wr), 32'd1);
        checkOutput("st_mem_rd", 32'(bus.mem_rd), 32'd0);
        checkOutput("st_mem_addr", 32'(bus.mem_addr), 32'd5);
        checkOutput("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 15'd5, 1'b0, 1'b0, 15'd0, 32'h0);
        checkOutput("st_no_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        checkOutput("st_no_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        checkOutput("stf_if_gnt", 32'(bus.if_gnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 15'd0, 32'h0);
        checkOutput("stf_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        checkOutput("stf_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        checkOutput("stf_d_rvalid", 32'(bus.d_rvalid), 32'd0);

        // Starvation: loads at 7 and fetches at 3 both held high. The grant
        // pattern repeats D,D,D,D,F, and the wait count seen before each edge
        // runs 0,1,2,3,4.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, 15'd3, 1'b1, 1'b0, 15'd7, 32'h0);
            checkOutput("sv_wait_cnt", 32'(dut.wait_cnt_q), 32'(i % 5));
            checkOutput("sv_if_gnt", 32'(bus.if_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
            checkOutput("sv_d_gnt", 32'(bus.d_gnt), (i % 5 == 4) ? 32'd0 : 32'd1);
            checkOutput("sv_if_stall", 32'(bus.if_stall), (i % 5 == 4) ? 32'd0 : 32'd1);
            checkOutput("sv_mem_addr", 32'(bus.mem_addr), (i % 5 == 4) ? 32'd3 : 32'd7);
            if (i > 0) begin
                checkOutput("sv_d_rvalid", 32'(bus.d_rvalid), ((i - 1) % 5 == 4) ? 32'd0 : 32'd1);
                checkOutput("sv_if_rvalid", 32'(bus.if_rvalid), ((i - 1) % 5 == 4) ? 32'd1 : 32'd0);
            end
        end
        applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 15'd0, 32'h0);
        checkOutput("sv_end_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        checkOutput("sv_end_d_rdata", bus.d_rdata, 32'hA000_0007);
        checkOutput("sv_end_if_rdata", bus.if_rdata, 32'hA000_0003);

        // Routing: alternate a load at 8 and a fetch at 9. Each read data
        // register changes only on its own capture.
        applyStimulus(1'b0, 1'b0, 15'd0, 1'b1, 1'b0, 15'd8, 32'h0);
        checkOutput("rt_d_gnt", 32'(bus.d_gnt), 32'd1);
        applyStimulus(1'b0, 1'b1, 15'd9, 1'b0, 1'b0, 15'd0, 32'h0);
        checkOutput("rt_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        checkOutput("rt_d_rdata", bus.d_rdata, 32'hA000_0008);
        checkOutput("rt_if_rvalid_lo", 32'(bus.if_rvalid), 32'd0);
        checkOutput("rt_if_rdata_hold", bus.if_rdata, 32'hA000_0003);
        applyStimulus(1'b0, 1'b0, 15'd0, 1'b1, 1'b0, 15'd8, 32'h0);
        checkOutput("rt_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        checkOutput("rt_if_rdata", bus.if_rdata, 32'hA000_0009);
        checkOutput("rt_d_rvalid_lo", 32'(bus.d_rvalid), 32'd0);
        checkOutput("rt_d_rdata_hold", bus.d_rdata, 32'hA000_0008);
        applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 15'd0, 32'h0);
        checkOutput("rt_d_rvalid2", 32'(bus.d_rvalid), 32'd1);
        checkOutput("rt_if_rdata_hold2", bus.if_rdata, 32'hA000_0009);

        // Reset the cycle after a load grant. The response registered at that
        // grant is still visible while reset is high. Reset then drops it.
        applyStimulus(1'b0, 1'b0, 15'd0, 1'b1, 1'b0, 15'd10, 32'h0);
        checkOutput("mr_d_gnt", 32'(bus.d_gnt), 32'd1);
        applyStimulus(1'b1, 1'b1, 15'd4, 1'b1, 1'b0, 15'd11, 32'h0);
        checkOutput("mr_pending_rvalid", 32'(bus.d_rvalid), 32'd1);
        checkOutput("mr_pending_rdata", bus.d_rdata, 32'hA000_000A);
        checkOutput("mr_rst_gnts", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd0);
        checkOutput("mr_rst_stall", 32'(bus.if_stall), 32'd1);
        applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 15'd0, 32'h0);
        checkOutput("mr_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        checkOutput("mr_d_rdata", bus.d_rdata, 32'h0);
        checkOutput("mr_if_rdata", bus.if_rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
